// File: rtl/uart_tx_fifo_if.sv
// Byte stream bundle between the CPU write port, the FIFO and the UART transmitter input.
// The slave modport is the FIFO's view; the master modport is the surrounding CPU/transmitter side.
interface uart_tx_fifo_if;
    logic [7:0] WrData;
    logic       WrValid;
    logic       WrReady;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;

    modport master (
        output WrData, WrValid, DataOutReady,
        input  WrReady, DataOut, DataOutValid
    );

    modport slave (
        input  WrData, WrValid, DataOutReady,
        output WrReady, DataOut, DataOutValid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// Also provides a fill count and a sticky overflow flag for polling software.
module uart_tx_fifo #(
    parameter  int unsigned Depth     = 16,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Flush,
    uart_tx_fifo_if.slave        bus,
    output logic [AddrWidth:0]   Count,
    output logic                 DropErr,
    input  logic                 DropClr
);

    localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);

    logic [7:0]           mem [Depth];
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth:0]   count;
    logic                 drop_err;
    logic                 wr_ready;
    logic                 rd_valid;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Handshake status comes only from the registered count, so a full FIFO
    // being popped still refuses a write in the same cycle.
    always_comb begin
        wr_ready = (count != FullCount);
        rd_valid = (count != '0);
        push     = bus.WrValid && wr_ready;
        pop      = rd_valid && bus.DataOutReady;
        drop     = bus.WrValid && !wr_ready;
    end

    always_ff @(posedge Clock) begin
        if (push && !Flush) begin
            mem[wr_ptr] <= bus.WrData;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new drop wins over a clear in the same cycle so no event is lost.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end else if (DropClr) begin
            drop_err <= 1'b0;
        end
    end

    assign bus.WrReady      = wr_ready;
    assign bus.DataOutValid = rd_valid;
    assign bus.DataOut      = mem[rd_ptr];
    assign Count            = count;
    assign DropErr          = drop_err;

endmodule
